alu_req_driver: RTL

- Initiator side of the 16-bit ALU operand/select interface.
- Accepts operation requests over a valid/ready handshake and buffers them in an in-order FIFO.
- Drives registered a/b/sel into the ALU and samples its result one settle cycle later.
- Returns result plus error flag over a second valid/ready handshake. Sits between the test/command source and the ALU.

---
 rtl/alu_pkg.sv | 31 +++
 rtl/alu_req_fifo.sv | 53 +++++
 rtl/alu_req_driver.sv | 116 +++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared types for the ALU request driver: op encoding, FIFO payload and FSM states.
package alu_pkg;

    localparam int DATA_W = 16;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_XOR
    } alu_op_e;

    // op is a raw 3-bit field so that illegal encodings still reach the ALU.
    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [2:0]        op;
    } alu_req_t;

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        RESP
    } drv_state_e;

    function automatic logic is_illegal_op(input logic [2:0] op);
        return op > 3'(ALU_XOR);
    endfunction

endpackage

// File: rtl/alu_req_fifo.sv
// In-order request buffer of alu_req_t; the head entry is visible combinationally on head.
module alu_req_fifo
    import alu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     push,
    input  alu_req_t push_data,
    input  logic     pop,
    output alu_req_t head,
    output logic     full,
    output logic     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    alu_req_t        mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     count;

    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

    // NOTE: storage has no reset; the pointers and count alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/alu_req_driver.sv
// Initiator for the 16-bit ALU: buffers requests, drives registered operands, returns
// the sampled result in request order over a valid/ready response channel.
module alu_req_driver
    import alu_pkg::*;
#(
    parameter int DATA_W = alu_pkg::DATA_W,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = $clog2(DEPTH+2)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [DATA_W-1:0] req_a,
    input  logic [DATA_W-1:0] req_b,
    input  logic [2:0]        req_op,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [2:0]        alu_sel,
    input  logic [DATA_W-1:0] alu_out,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic [2:0]        rsp_op,
    output logic              rsp_err,
    output logic [CNT_W-1:0]  pending
);

    drv_state_e state, state_next;
    alu_req_t   push_data, head;
    logic       fifo_full, fifo_empty;
    logic       push, pop, rsp_hs;

    assign req_ready = !fifo_full;
    assign push      = req_valid && req_ready;
    assign rsp_hs    = rsp_valid && rsp_ready;
    assign push_data = '{a: req_a, b: req_b, op: req_op};

    alu_req_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // NOTE: defaults first so no path through this block leaves a signal unassigned (no latches).
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    state_next = DRIVE;
                end
            end
            DRIVE: state_next = RESP;
            RESP: begin
                if (rsp_hs) begin
                    pop        = !fifo_empty;
                    state_next = fifo_empty ? IDLE : DRIVE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // alu_* only move on a pop, so the ALU sees stable operands throughout DRIVE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_a     <= '0;
            alu_b     <= '0;
            alu_sel   <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_op    <= '0;
            rsp_err   <= 1'b0;
        end else begin
            if (pop) begin
                alu_a   <= head.a;
                alu_b   <= head.b;
                alu_sel <= head.op;
            end
            if (state == DRIVE) begin
                rsp_data  <= alu_out;
                rsp_op    <= alu_sel;
                rsp_err   <= is_illegal_op(alu_sel);
                rsp_valid <= 1'b1;
            end else if (rsp_hs) begin
                rsp_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= '0;
        end else begin
            case ({push, rsp_hs})
                2'b10:   pending <= pending + CNT_W'(1);
                2'b01:   pending <= pending - CNT_W'(1);
                default: pending <= pending;
            endcase
        end
    end

endmodule
